// File: rtl/multicycle_core.sv
// multicycle_core: LEGv8-subset multicycle CPU core with handshaked instruction and data ports
module multicycle_core #(
  parameter int XLEN = 64,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic            CLK,
  input  logic            reset,
  input  logic [XLEN-1:0] startpc,
  output logic [XLEN-1:0] currentpc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            retire,
  output logic            halted
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  state_t state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, a_q, a_d, b_q, b_d, imm_q, imm_d, res_q, res_d;
  logic [XLEN-1:0] rf_q [32];
  logic [31:0] ir_q, ir_d;
  logic [XLEN-1:0] pc4, rn_val, rm_val, movz_imm, alu;
  logic [4:0] rm_idx;
  logic is_add, is_sub, is_and, is_orr, is_ld, is_st, is_cbz, is_b, is_movz, is_rtype;
  assign is_add = ir_q[31:21] == 11'b10001011000;
  assign is_sub = ir_q[31:21] == 11'b11001011000;
  assign is_and = ir_q[31:21] == 11'b10001010000;
  assign is_orr = ir_q[31:21] == 11'b10101010000;
  assign is_ld = ir_q[31:21] == 11'b11111000010;
  assign is_st = ir_q[31:21] == 11'b11111000000;
  assign is_cbz = ir_q[31:24] == 8'b10110100;
  assign is_b = ir_q[31:26] == 6'b000101;
  // a 32-bit core cannot shift a halfword past bit 31, so hw 2 and 3 are not MOVZ there
  assign is_movz = ir_q[31:23] == 9'b110100101 && (XLEN == 64 || !ir_q[22]);
  assign is_rtype = is_add | is_sub | is_and | is_orr;
  assign rm_idx = (is_st | is_cbz) ? ir_q[4:0] : ir_q[20:16];
  assign rn_val = ir_q[9:5] == 5'd31 ? '0 : rf_q[ir_q[9:5]];
  assign rm_val = rm_idx == 5'd31 ? '0 : rf_q[rm_idx];
  assign movz_imm = XLEN'(ir_q[20:5]) << {ir_q[22:21], 4'b0};
  assign alu = is_add ? a_q + b_q : is_sub ? a_q - b_q : is_and ? a_q & b_q :
               is_orr ? a_q | b_q : is_movz ? imm_q : a_q + imm_q;
  assign pc4 = pc_q + XLEN'(4);
  assign currentpc = reset ? startpc : pc_q;
  assign imem_addr = currentpc;
  assign dmem_addr = res_q;
  assign dmem_wdata = b_q;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ir_d = ir_q;
    a_d = a_q;
    b_d = b_q;
    imm_d = imm_q;
    res_d = res_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we = 1'b0;
    retire = 1'b0;
    halted = 1'b0;
    case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        ir_d = imem_ready ? imem_rdata : ir_q;
        state_d = imem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        a_d = rn_val;
        b_d = rm_val;
        imm_d = is_movz ? movz_imm :
                is_b ? {{(XLEN-26){ir_q[25]}}, ir_q[25:0]} << 2 :
                is_cbz ? {{(XLEN-19){ir_q[23]}}, ir_q[23:5]} << 2 :
                {{(XLEN-9){ir_q[20]}}, ir_q[20:12]};
        state_d = EXEC;
      end
      EXEC: begin
        res_d = alu;
        if (is_ld | is_st) state_d = MEM;
        else if (is_rtype | is_movz) state_d = WB;
        else if (is_b | is_cbz) begin
          pc_d = (is_b || b_q == '0) ? pc_q + imm_q : pc4;
          retire = 1'b1;
          state_d = FETCH;
        end else if (HALT_ON_ILLEGAL) state_d = HALT;
        else begin
          pc_d = pc4;
          retire = 1'b1;
          state_d = FETCH;
        end
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we = is_st;
        res_d = (dmem_ready && !is_st) ? dmem_rdata : res_q;
        pc_d = (dmem_ready && is_st) ? pc4 : pc_q;
        retire = dmem_ready && is_st;
        state_d = !dmem_ready ? MEM : is_st ? FETCH : WB;
      end
      WB: begin
        pc_d = pc4;
        retire = 1'b1;
        state_d = FETCH;
      end
      HALT: halted = 1'b1;
      default: state_d = FETCH;
    endcase
    if (reset) {imem_req, dmem_req, dmem_we, retire, halted} = '0;
  end
  always_ff @(posedge CLK) begin
    state_q <= reset ? FETCH : state_d;
    pc_q <= reset ? startpc : pc_d;
    ir_q <= ir_d;
    a_q <= a_d;
    b_q <= b_d;
    imm_q <= imm_d;
    res_q <= res_d;
  end
  always_ff @(posedge CLK)
    if (!reset && state_q == WB && ir_q[4:0] != 5'd31) rf_q[ir_q[4:0]] <= res_q;
endmodule

// File: tb/tb_multicycle_core.sv
// tb_multicycle_core: scoreboard bench; 64-bit core with memory models, plus a 32-bit core running a wrap/X31 program
module tb_multicycle_core;
  localparam logic [10:0] OP_ADD = 11'b10001011000, OP_SUB = 11'b11001011000;
  localparam logic [10:0] OP_AND = 11'b10001010000, OP_ORR = 11'b10101010000;
  localparam logic [10:0] OP_LD = 11'b11111000010, OP_ST = 11'b11111000000;
  typedef struct {int kind; logic [63:0] a; logic [63:0] d;} ev_t;
  logic clk = 1'b0, reset = 1'b1, reset32 = 1'b1;
  logic [63:0] startpc = 64'h100;
  logic [63:0] currentpc, imem_addr, dmem_addr, dmem_wdata, dmem_rdata;
  logic imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, retire, halted;
  logic [31:0] imem_rdata;
  logic [31:0] currentpc32, imem_addr32, dmem_addr32, dmem_wdata32, dmem_rdata32, imem_rdata32;
  logic imem_req32, imem_ready32, dmem_req32, dmem_we32, dmem_ready32, retire32, halted32;
  logic [31:0] imem [logic [63:0]];
  logic [63:0] dmem [logic [63:0]];
  ev_t q[$], q32[$];
  int n_vec = 0, n_fail = 0, ic = 0, dc = 0;
  longint cyc = 0, last_ret = 0;
  logic pi_req, pi_rdy, pd_req, pd_rdy, pd_we;
  logic [63:0] pi_addr, pd_addr, pd_wdata;
  always #5 clk = ~clk;
  multicycle_core #(.XLEN(64), .HALT_ON_ILLEGAL(1'b1)) dut (
    .CLK(clk), .reset(reset), .startpc(startpc), .currentpc(currentpc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .retire(retire), .halted(halted));
  multicycle_core #(.XLEN(32), .HALT_ON_ILLEGAL(1'b0)) dut32 (
    .CLK(clk), .reset(reset32), .startpc(32'h0), .currentpc(currentpc32),
    .imem_req(imem_req32), .imem_addr(imem_addr32), .imem_ready(imem_ready32), .imem_rdata(imem_rdata32),
    .dmem_req(dmem_req32), .dmem_we(dmem_we32), .dmem_addr(dmem_addr32), .dmem_wdata(dmem_wdata32),
    .dmem_ready(dmem_ready32), .dmem_rdata(dmem_rdata32), .retire(retire32), .halted(halted32));
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask
  function automatic logic [31:0] f_r(input logic [10:0] op, input int rm, input int rn, input int rd);
    return {op, 5'(rm), 6'd0, 5'(rn), 5'(rd)};
  endfunction
  function automatic logic [31:0] f_mz(input int rd, input int imm, input int hw);
    return {9'b110100101, 2'(hw), 16'(imm), 5'(rd)};
  endfunction
  function automatic logic [31:0] f_d(input logic [10:0] op, input int imm, input int rn, input int rt);
    return {op, 9'(imm), 2'b00, 5'(rn), 5'(rt)};
  endfunction
  function automatic logic [31:0] f_cbz(input int imm, input int rt);
    return {8'b10110100, 19'(imm), 5'(rt)};
  endfunction
  function automatic logic [31:0] f_b(input int imm);
    return {6'b000101, 26'(imm)};
  endfunction
  function automatic logic [31:0] prog32(input logic [31:0] a);
    case (a)
      32'h00: return f_mz(1, 1, 0);
      32'h04: return f_r(OP_SUB, 1, 31, 2);
      32'h08: return f_mz(31, 9, 0);
      32'h0C: return f_d(OP_ST, 0, 31, 2);
      32'h10: return f_d(OP_ST, 4, 31, 31);
      32'h14: return 32'hFFFFFFFF;
      32'h18: return f_mz(3, 1, 2);
      32'h1C: return f_r(OP_ADD, 1, 2, 4);
      32'h20: return f_d(OP_ST, 8, 31, 4);
      default: return f_b(0);
    endcase
  endfunction
  task automatic put(input logic [63:0] a, input logic [31:0] w);
    imem[a] = w;
  endtask
  task automatic ret(input logic [63:0] pc, input int gap);
    q.push_back('{0, pc, 64'(gap)});
  endtask
  task automatic st(input logic [63:0] a, input logic [63:0] d);
    q.push_back('{1, a, d});
  endtask
  // memory models respond just after the clock edge so the monitor sees settled values
  always @(posedge clk) begin
    #1;
    if (reset || !imem_req) begin imem_ready = 1'b0; ic = 0; end
    else if (ic == (imem_addr == 64'h2FC ? 10 : 0)) begin
      imem_ready = 1'b1;
      imem_rdata = imem.exists(imem_addr) ? imem[imem_addr] : 32'hFFFFFFFF;
      ic = 0;
    end else begin imem_ready = 1'b0; ic++; end
    if (reset || !dmem_req) begin dmem_ready = 1'b0; dc = 0; end
    else if (dc == 3) begin
      dmem_ready = 1'b1;
      if (dmem_we) dmem[dmem_addr] = dmem_wdata;
      else dmem_rdata = dmem.exists(dmem_addr) ? dmem[dmem_addr] : 64'h0;
      dc = 0;
    end else begin dmem_ready = 1'b0; dc++; end
    imem_ready32 = imem_req32 && !reset32;
    imem_rdata32 = prog32(imem_addr32);
    dmem_ready32 = dmem_req32 && !reset32;
    dmem_rdata32 = 32'h0;
  end
  always @(negedge clk) begin
    ev_t e;
    if (reset) begin
      pi_req = 1'b0;
      pd_req = 1'b0;
    end else begin
      cyc++;
      chk("req_exclusive", imem_req & dmem_req, 0);
      if (pi_req && !pi_rdy && imem_req) chk("imem_addr_hold", imem_addr, pi_addr);
      if (pd_req && !pd_rdy && dmem_req) begin
        chk("dmem_addr_hold", dmem_addr, pd_addr);
        chk("dmem_wdata_hold", dmem_wdata, pd_wdata);
        chk("dmem_we_hold", dmem_we, pd_we);
      end
      if (dmem_req && dmem_ready) begin
        chk("mem_event_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("mem_kind", dmem_we ? 1 : 2, 64'(e.kind));
          chk("mem_addr", dmem_addr, e.a);
          if (e.kind == 1) chk("mem_wdata", dmem_wdata, e.d);
        end
      end
      if (retire) begin
        chk("retire_expected", q.size() > 0, 1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("ret_kind", 0, 64'(e.kind));
          chk("ret_pc", currentpc, e.a);
          if (e.d != 0) chk("ret_gap", 64'(cyc - last_ret), e.d);
        end
        last_ret = cyc;
      end
      {pi_req, pi_rdy, pi_addr} = {imem_req, imem_ready, imem_addr};
      {pd_req, pd_rdy, pd_we, pd_addr, pd_wdata} = {dmem_req, dmem_ready, dmem_we, dmem_addr, dmem_wdata};
    end
    if (!reset32) begin
      chk("u32_not_halted", halted32, 0);
      if (dmem_req32 && dmem_ready32) begin
        chk("u32_mem_expected", q32.size() > 0, 1);
        if (q32.size() > 0) begin
          e = q32.pop_front();
          chk("u32_mem_we", dmem_we32, 1);
          chk("u32_mem_addr", dmem_addr32, e.a);
          chk("u32_mem_wdata", dmem_wdata32, e.d);
        end
      end
    end
  end
  initial begin
    put(64'h100, f_mz(1, 5, 0));           ret(64'h100, 0);
    put(64'h104, f_mz(2, 7, 0));           ret(64'h104, 4);
    put(64'h108, f_r(OP_ADD, 2, 1, 3));    ret(64'h108, 4);
    put(64'h10C, f_d(OP_ST, 8, 31, 3));    st(64'h8, 64'd12); ret(64'h10C, 7);
    put(64'h110, f_d(OP_LD, 8, 31, 4));    q.push_back('{2, 64'h8, 64'h0}); ret(64'h110, 8);
    put(64'h114, f_d(OP_ST, 16, 31, 4));   st(64'h10, 64'd12); ret(64'h114, 7);
    put(64'h118, f_b(58));                 ret(64'h118, 3);
    put(64'h200, f_cbz(3, 31));            ret(64'h200, 3);
    put(64'h20C, f_cbz(3, 1));             ret(64'h20C, 3);
    put(64'h210, f_b(60));                 ret(64'h210, 3);
    put(64'h300, f_b(-1));                 ret(64'h300, 3);
    put(64'h2FC, f_b(65));                 ret(64'h2FC, 13);
    put(64'h400, f_r(OP_SUB, 2, 1, 5));    ret(64'h400, 4);
    put(64'h404, f_r(OP_AND, 2, 1, 6));    ret(64'h404, 4);
    put(64'h408, f_r(OP_ORR, 2, 1, 7));    ret(64'h408, 4);
    put(64'h40C, f_mz(8, 16'h1234, 1));    ret(64'h40C, 4);
    put(64'h410, f_d(OP_ST, 32, 31, 5));   st(64'h20, 64'hFFFFFFFFFFFFFFFE); ret(64'h410, 7);
    put(64'h414, f_d(OP_ST, 40, 31, 6));   st(64'h28, 64'd5); ret(64'h414, 7);
    put(64'h418, f_d(OP_ST, 48, 31, 7));   st(64'h30, 64'd7); ret(64'h418, 7);
    put(64'h41C, f_d(OP_ST, 56, 31, 8));   st(64'h38, 64'h12340000); ret(64'h41C, 7);
    put(64'h420, f_mz(31, 9, 0));          ret(64'h420, 4);
    put(64'h424, f_d(OP_ST, 64, 31, 31));  st(64'h40, 64'h0); ret(64'h424, 7);
    put(64'h428, f_d(OP_ST, -8, 31, 6));   st(64'hFFFFFFFFFFFFFFF8, 64'd5); ret(64'h428, 7);
    put(64'h42C, f_mz(9, 16'hABCD, 3));    ret(64'h42C, 4);
    put(64'h430, f_d(OP_ST, 72, 31, 9));   st(64'h48, 64'hABCD000000000000); ret(64'h430, 7);
    put(64'h434, 32'hFFFFFFFF);
    put(64'h500, f_d(OP_ST, 80, 31, 3));
    put(64'h504, 32'hFFFFFFFF);
    q32.push_back('{1, 64'h0, 64'hFFFFFFFF});
    q32.push_back('{1, 64'h4, 64'h0});
    q32.push_back('{1, 64'h8, 64'h0});
    repeat (3) @(negedge clk);
    chk("rst_currentpc", currentpc, 64'h100);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_retire", retire, 0);
    chk("rst_halted", halted, 0);
    reset = 1'b0;
    reset32 = 1'b0;
    #1 chk("first_fetch_addr", imem_addr, 64'h100);
    chk("first_fetch_req", imem_req, 1);
    for (int i = 0; i < 3000 && (q.size() > 0 || q32.size() > 0); i++) @(negedge clk);
    chk("scoreboard_drained", q.size() + q32.size(), 0);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("halt_state", {halted, retire, imem_req, dmem_req}, 4'b1000);
    end
    reset = 1'b1;
    startpc = 64'h500;
    st(64'h50, 64'd12);
    ret(64'h500, 0);
    @(negedge clk);
    chk("rst2_currentpc", currentpc, 64'h500);
    chk("rst2_halted", halted, 0);
    chk("rst2_imem_req", imem_req, 0);
    reset = 1'b0;
    #1 chk("refetch_addr", imem_addr, 64'h500);
    for (int i = 0; i < 200 && q.size() > 0; i++) @(negedge clk);
    chk("scoreboard2_drained", q.size(), 0);
    repeat (6) @(negedge clk);
    chk("halt2", halted, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/multicycle_core.md
MULTICYCLE_CORE -- requirements
Module: multicycle_core

Interface
REQ-001 Parameter XLEN, default 64: datapath, register, PC and data-address width; legal values 32 and 64.
REQ-002 Parameter HALT_ON_ILLEGAL, default 1: 1 sends an unrecognised opcode to HALT; 0 retires it as a NOP.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 startpc  input  XLEN  PC value loaded during reset.
REQ-006 currentpc  output  XLEN  PC of the instruction in flight.
REQ-007 imem_req  output  1  instruction fetch request; imem_addr  output  XLEN  fetch address (= currentpc).
REQ-008 imem_ready  input  1  fetch complete; imem_rdata  input  32  instruction word, valid when imem_ready=1.
REQ-009 dmem_req  output  1  data access request; dmem_we  output  1  1 = store, 0 = load.
REQ-010 dmem_addr  output  XLEN  data address; dmem_wdata  output  XLEN  store data.
REQ-011 dmem_ready  input  1  access complete; dmem_rdata  input  XLEN  load data, valid when dmem_ready=1.
REQ-012 retire  output  1  one-cycle pulse per completed instruction; halted  output  1  core stopped.

Function
REQ-013 Internal register file: 32 x XLEN; X31 reads as 0; writes to X31 are discarded.
REQ-014 The FSM has states FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-015 FETCH: drive imem_req=1 and hold imem_addr stable until imem_ready=1; then latch imem_rdata into IR and go to DECODE. Wait cycles are unbounded.
REQ-016 DECODE: read Rn=IR[9:5] and Rm=IR[20:16]. For STUR and CBZ, read IR[4:0] as the second operand. Sign- or zero-extend the immediate to XLEN. Go to EXEC.
REQ-017 Supported instructions, with opcode bits:
- ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000
- LDUR 11111000010, STUR 11111000000 (address = Rn + sign-extended IR[20:12])
- CBZ 10110100 (IR[31:24]); B 000101 (IR[31:26])
- MOVZ 110100101 (IR[31:23]): IR[20:5] shifted left by 16*IR[22:21] bits. With XLEN=32, hw values 2 and 3 are illegal.
REQ-018 EXEC, R-type and MOVZ: compute the result and go to WB.
REQ-019 EXEC, LDUR/STUR: compute the address and go to MEM.
REQ-020 EXEC, B: set PC to PC + (sext(IR[25:0]) << 2), pulse retire, go to FETCH.
REQ-021 EXEC, CBZ: if the operand is 0, set PC to PC + (sext(IR[23:5]) << 2); otherwise PC to PC+4. Pulse retire and go to FETCH.
REQ-022 MEM: hold dmem_req=1 with dmem_addr, dmem_we and dmem_wdata stable until dmem_ready=1.
- Load: latch dmem_rdata and go to WB.
- Store: set PC to PC+4, pulse retire, go to FETCH.
REQ-023 WB: write the result to Rd=IR[4:0], set PC to PC+4, pulse retire, go to FETCH.
REQ-024 Zero-wait latency: R-type/MOVZ 4 cycles, LDUR 5, STUR 4, B/CBZ 3.
REQ-025 All arithmetic is modulo 2^XLEN; the PC wraps silently.
REQ-026 Illegal opcode with HALT_ON_ILLEGAL=1: go to HALT with halted=1 and retire=0. HALT is exited only by reset.
REQ-027 Illegal opcode with HALT_ON_ILLEGAL=0: set PC to PC+4, pulse retire, go to FETCH.
REQ-028 imem_req and dmem_req are never asserted in the same cycle.
REQ-029 A ready input arriving while the corresponding req=0 is ignored.

Reset
REQ-030 While reset=1:
- state = FETCH, currentpc = startpc
- imem_req = dmem_req = dmem_we = retire = halted = 0
- register file contents unchanged
REQ-031 Reset asserted mid-fetch or mid-access abandons the transaction immediately; no register or PC update from it.
REQ-032 The first imem_req is asserted in the cycle after reset deasserts.

Verification
REQ-033 startpc=0x100, imem_ready tied 1; MOVZ X1,#5; MOVZ X2,#7; ADD X3,X1,X2 -> X3=12, retire every 4 cycles, currentpc=0x10C.
REQ-034 STUR X3,[X0,#8] then LDUR X4,[X0,#8], with dmem_ready delayed 3 cycles -> dmem_addr=8, dmem_wdata=12, X4=12; address and data stable throughout each wait.
REQ-035 CBZ X31,+3 at 0x200 -> next fetch 0x20C; CBZ X1 (X1=5) at 0x200 -> next fetch 0x204.
REQ-036 B -1 at 0x300 -> next fetch 0x2FC; imem_ready held low 10 cycles -> imem_addr constant, no retire.
REQ-037 Word 0xFFFFFFFF, HALT_ON_ILLEGAL=1 -> halted=1, no further req. A subsequent reset clears halted and refetches at startpc.
REQ-038 Writes to X31, plus XLEN=32 SUB 0-1 -> X31 reads 0; the SUB result is 0xFFFFFFFF.
